// File: rtl/instr_enc_pkg.sv
// Shared encodings for the instruction stream encoder.
// Opcodes, functs, ALU op codes, class and FSM state types.
package instr_enc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_LW  = 3'd1,
    CLS_SW  = 3'd2,
    CLS_BEQ = 3'd3,
    CLS_J   = 3'd4
  } cls_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/instr_word_pack.sv
// Combinational field-to-word packer for MIPS R/LW/SW/BEQ/J.
// legal is low for unknown classes and unlisted R-type ALU ops.
module instr_word_pack
  import instr_enc_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [2:0]  alu_op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal,
  output logic        is_br
);

  logic [5:0] funct;
  logic       fn_ok;

  always_comb begin
    funct = 6'h00;
    fn_ok = 1'b1;
    unique case (alu_op)
      ALU_ADD: funct = FN_ADD;
      ALU_SUB: funct = FN_SUB;
      ALU_AND: funct = FN_AND;
      ALU_OR:  funct = FN_OR;
      ALU_SLT: funct = FN_SLT;
      default: fn_ok = 1'b0;
    endcase
  end

  always_comb begin
    word  = 32'h0;
    legal = 1'b0;
    is_br = 1'b0;
    unique case (1'b1)
      cls == CLS_R: begin
        word  = {OP_RTYPE, rs, rt, rd, 5'd0, funct};
        legal = fn_ok;
      end
      cls == CLS_LW: begin
        word  = {OP_LW, rs, rt, imm};
        legal = 1'b1;
      end
      cls == CLS_SW: begin
        word  = {OP_SW, rs, rt, imm};
        legal = 1'b1;
      end
      cls == CLS_BEQ: begin
        word  = {OP_BEQ, rs, rt, imm};
        legal = 1'b1;
        is_br = 1'b1;
      end
      cls == CLS_J: begin
        word  = {OP_J, target};
        legal = 1'b1;
        is_br = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Encodes field bundles into MIPS words and writes them to imem.
// ENC_DELAY_SLOT_NOP_EN: insert a NOP after every BEQ/J word.
module instr_stream_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [2:0]        in_alu_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W:0]   C_ONE   = 1;

  state_e            state;
  state_e            state_nx;
  logic [ADDR_W-1:0] addr_ptr;
  logic [ADDR_W-1:0] nxt_addr;
  logic              fin_seen;
  logic [31:0]       pk_word;
  logic              pk_legal;
  logic              pk_br;
  logic              accept;
  logic              wr_fire;
  logic              init;
  logic              room;
  logic              full;
  logic              hold;
  logic              nop_go;
  logic              nop_err;
  logic [ADDR_W+1:0] used;

  instr_word_pack u_pack (
    .cls    (in_class),
    .alu_op (in_alu_op),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .imm    (in_imm),
    .target (in_target),
    .word   (pk_word),
    .legal  (pk_legal),
    .is_br  (pk_br)
  );

  assign wr_fire  = imem_we & imem_ready;
  assign accept   = in_valid & in_ready;
  assign init     = start & (state != RUN);
  assign full     = (count == DEPTH_C);
  assign used     = {1'b0, count} + {{(ADDR_W+1){1'b0}}, imem_we};
  assign room     = used < DEPTH_X;
  assign nxt_addr = addr_ptr + {{(ADDR_W-1){1'b0}}, wr_fire};
  assign done     = (state == DONE);

`ifdef ENC_DELAY_SLOT_NOP_EN
  logic out_br;
  logic nop_room;

  // out_br marks a branch/jump word sitting in the output register
  always_ff @(posedge clk) begin
    if (reset)
      out_br <= 1'b0;
    else if (accept & pk_legal)
      out_br <= pk_br;
    else if (wr_fire)
      out_br <= 1'b0;
  end

  assign nop_room = ({1'b0, count} + {1'b0, C_ONE}) < DEPTH_X;
  assign hold     = imem_we & out_br;
  assign nop_go   = wr_fire & out_br & nop_room;
  assign nop_err  = wr_fire & out_br & ~nop_room;
`else
  logic unused_br;
  assign unused_br = pk_br;
  assign hold      = 1'b0;
  assign nop_go    = 1'b0;
  assign nop_err   = 1'b0;
`endif

  assign in_ready = (state == RUN) & ~fin_seen & room
                  & (~imem_we | imem_ready) & ~hold;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start)
          state_nx = RUN;
      RUN:
        if (~imem_we & (fin_seen | full))
          state_nx = DONE;
      DONE:
        if (start)
          state_nx = RUN;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_ptr <= '0;
      count    <= '0;
      fin_seen <= 1'b0;
      err      <= 1'b0;
    end else if (init) begin
      addr_ptr <= start_addr;
      count    <= '0;
      fin_seen <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (wr_fire) begin
        count    <= count + C_ONE;
        addr_ptr <= nxt_addr;
      end
      if ((state == RUN) & finish)
        fin_seen <= 1'b1;
      if (accept & ~pk_legal)
        err <= 1'b1;
      if ((state == RUN) & in_valid & full)
        err <= 1'b1;
      if (nop_err)
        err <= 1'b1;
    end
  end

  // Output register: a write drains it, a legal accept or NOP refills it
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
    end else begin
      if (wr_fire)
        imem_we <= 1'b0;
      if (nop_go) begin
        imem_we    <= 1'b1;
        imem_addr  <= nxt_addr;
        imem_wdata <= 32'h0;
      end
      if (accept & pk_legal) begin
        imem_we    <= 1'b1;
        imem_addr  <= nxt_addr;
        imem_wdata <= pk_word;
      end
    end
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder (DEPTH=4 instance).
// Honours ENC_DELAY_SLOT_NOP_EN in the branch expectations.
module tb_instr_stream_encoder;
  import instr_enc_pkg::*;

  localparam int AW = 8;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          finish;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_class;
  logic [2:0]    in_alu_op;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          imem_we;
  logic          imem_ready;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          done;
  logic          err;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int acc_cyc = 0;

  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  int            wc[$];

  instr_stream_encoder #(.ADDR_W(AW), .DEPTH(DP)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .finish     (finish),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_class   (in_class),
    .in_alu_op  (in_alu_op),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_target  (in_target),
    .imem_we    (imem_we),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && imem_we && imem_ready) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
      wc.push_back(cyc);
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx,
                        input logic [AW-1:0] a, input logic [31:0] d);
    check({tag, "_present"}, 32'(wa.size() > idx), 32'd1);
    if (wa.size() > idx) begin
      check({tag, "_addr"}, 32'(wa[idx]), 32'(a));
      check({tag, "_data"}, wd[idx], d);
    end
  endtask

  task automatic send(input logic [2:0] c, input logic [2:0] op,
                      input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [15:0] im,
                      input logic [25:0] tg);
    int n;
    n = 0;
    @(negedge clk);
    in_class  = c;
    in_alu_op = op;
    in_rs     = s;
    in_rt     = t;
    in_rd     = d;
    in_imm    = im;
    in_target = tg;
    in_valid  = 1'b1;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40)
      check("send_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic begin_session(input logic [AW-1:0] a);
    @(negedge clk);
    start      = 1'b1;
    start_addr = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done", 32'(done), 32'd1);
  endtask

  task automatic end_session();
    @(negedge clk);
    finish = 1'b1;
    @(posedge clk);
    #1;
    finish = 1'b0;
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    finish     = 1'b0;
    in_valid   = 1'b0;
    in_class   = 3'd0;
    in_alu_op  = 3'd0;
    in_rs      = 5'd0;
    in_rt      = 5'd0;
    in_rd      = 5'd0;
    in_imm     = 16'h0;
    in_target  = 26'h0;
    imem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'h0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // single R-type add, one-cycle latency
    begin_session(8'h10);
    send(CLS_R, ALU_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    check("add_we", 32'(imem_we), 32'd1);
    check("add_addr", 32'(imem_addr), 32'h10);
    check("add_wdata", imem_wdata, 32'h00221820);
    @(posedge clk);
    #1;
    check("add_count", 32'(count), 32'd1);
    check("add_wrcyc", 32'(wc.size() > 0 ? wc[0] : -1), 32'(acc_cyc));
    end_session();
    check("add_fcount", 32'(count), 32'd1);

    // back-to-back LW/SW
    begin_session(8'h10);
    send(CLS_LW, 3'd0, 5'd4, 5'd5, 5'd0, 16'h0010, 26'h0);
    send(CLS_SW, 3'd0, 5'd4, 5'd5, 5'd0, 16'hfffc, 26'h0);
    end_session();
    chk_wr("lw", 0, 8'h10, 32'h8c850010);
    chk_wr("sw", 1, 8'h11, 32'hac85fffc);
    if (wc.size() > 1)
      check("b2b_gap", 32'(wc[1] - wc[0]), 32'd1);
    check("b2b_count", 32'(count), 32'd2);

    // remaining R-type ops fill DEPTH and end the session
    begin_session(8'h50);
    send(CLS_R, ALU_SUB, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0);
    send(CLS_R, ALU_AND, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
    send(CLS_R, ALU_OR,  5'd2, 5'd3, 5'd4, 16'h0, 26'h0);
    send(CLS_R, ALU_SLT, 5'd0, 5'd0, 5'd31, 16'h0, 26'h0);
    wait_done();
    chk_wr("sub", 0, 8'h50, 32'h00e84822);
    chk_wr("and", 1, 8'h51, 32'h00210824);
    chk_wr("or",  2, 8'h52, 32'h00432025);
    chk_wr("slt", 3, 8'h53, 32'h0000f82a);

    // branch and jump
    begin_session(8'h30);
    send(CLS_BEQ, 3'd0, 5'd1, 5'd2, 5'd0, 16'h0003, 26'h0);
    send(CLS_J, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40);
    end_session();
`ifdef ENC_DELAY_SLOT_NOP_EN
    chk_wr("beq", 0, 8'h30, 32'h10220003);
    chk_wr("nop0", 1, 8'h31, 32'h0);
    chk_wr("j", 2, 8'h32, 32'h08000040);
    chk_wr("nop1", 3, 8'h33, 32'h0);
    check("br_count", 32'(count), 32'd4);
`else
    chk_wr("beq", 0, 8'h30, 32'h10220003);
    chk_wr("j", 1, 8'h31, 32'h08000040);
    check("br_count", 32'(count), 32'd2);
`endif
    check("br_err", 32'(err), 32'd0);

    // imem back-pressure holds the output register
    begin_session(8'h20);
    send(CLS_LW, 3'd0, 5'd4, 5'd5, 5'd0, 16'h0010, 26'h0);
    imem_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_we", 32'(imem_we), 32'd1);
      check("stall_addr", 32'(imem_addr), 32'h20);
      check("stall_wdata", imem_wdata, 32'h8c850010);
      check("stall_rdy", 32'(in_ready), 32'd0);
      check("stall_count", 32'(count), 32'd0);
    end
    imem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_cnt1", 32'(count), 32'd1);
    send(CLS_SW, 3'd0, 5'd4, 5'd5, 5'd0, 16'hfffc, 26'h0);
    end_session();
    chk_wr("stall_w0", 0, 8'h20, 32'h8c850010);
    chk_wr("stall_w1", 1, 8'h21, 32'hac85fffc);

    // overflow with address wrap
    begin_session(8'hff);
    for (int k = 0; k < 4; k++)
      send(CLS_LW, 3'd0, 5'd1, 5'd2, 5'd0, 16'(k), 26'h0);
    @(negedge clk);
    in_class = CLS_LW;
    in_valid = 1'b1;
    check("ovf_rdy", 32'(in_ready), 32'd0);
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_done", 32'(done), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_nwr", 32'(wa.size()), 32'd4);
    chk_wr("ovf_w0", 0, 8'hff, 32'h8c220000);
    chk_wr("ovf_w1", 1, 8'h00, 32'h8c220001);
    chk_wr("ovf_w3", 3, 8'h02, 32'h8c220003);

    // illegal inputs consumed, then reset drops a pending write
    begin_session(8'h40);
    check("ill_err0", 32'(err), 32'd0);
    send(3'd5, 3'd0, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    check("ill_we", 32'(imem_we), 32'd0);
    check("ill_err", 32'(err), 32'd1);
    send(CLS_R, 3'b011, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
    repeat (2) @(negedge clk);
    check("ill_nwr", 32'(wa.size()), 32'd0);
    check("ill_count", 32'(count), 32'd0);
    send(CLS_LW, 3'd0, 5'd4, 5'd5, 5'd0, 16'h0010, 26'h0);
    imem_ready = 1'b0;
    check("pre_rst_we", 32'(imem_we), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_we", 32'(imem_we), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_rdy", 32'(in_ready), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_done", 32'(done), 32'd0);
    check("post_rst_we", 32'(imem_we), 32'd0);
    check("post_rst_nwr", 32'(wa.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/instr_stream_encoder.md
Name: instr_stream_encoder

Overview:
- Inverse of the opcode/funct decode path: accepts instruction fields over a valid/ready handshake and encodes them into 32-bit MIPS words.
- Supported classes: R-format, lw, sw, beq, j.
- Writes the encoded words into instruction memory at consecutive word addresses.
- Used for program load during bring-up and by the test infrastructure that feeds the single-cycle core.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 256, maximum words written per load session (must be no more than 2**ADDR_W)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
start  in  1  pulse: begin session at start_addr (honoured in IDLE/DONE only)
start_addr  in  ADDR_W  first word address of session
finish  in  1  pulse: end session after pending write drains
in_valid  in  1  field bundle valid
in_ready  out  1  encoder accepts bundle this cycle
in_class  in  3  0=R, 1=LW, 2=SW, 3=BEQ, 4=J, 5..7 illegal
in_alu_op  in  3  R-type operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
in_rs, in_rt, in_rd  in  5 each  register fields
in_imm  in  16  immediate/offset (LW/SW/BEQ)
in_target  in  26  jump target (J)
imem_we  out  1  write request
imem_ready  in  1  memory accepts write when imem_we and imem_ready are both high
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  encoded word
count  out  ADDR_W+1  words written this session
done  out  1  high in DONE state
err  out  1  sticky: illegal class/alu_op seen, or overflow attempt; cleared by start or reset

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, done=0, err=0; state=IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start: addr_ptr<=start_addr, count<=0, err<=0.
  - RUN -> DONE when the output register is empty and either (finish was seen) or (count==DEPTH).
  - DONE -> RUN on start, with the same initialisation as from IDLE. Otherwise DONE holds.
  - start in RUN is ignored.
- Handshake:
  - in_ready = (state==RUN) & (count + pending < DEPTH) & (~imem_we | imem_ready). No combinational path from in_valid to in_ready.
  - An accepted legal bundle is registered next cycle: imem_we=1, imem_wdata=encoded word, imem_addr=addr_ptr. Latency is 1 cycle from accept to imem_we.
  - imem_we/addr/wdata are held stable until imem_ready is high. On that write: count++ and addr_ptr++ (addr_ptr wraps modulo 2**ADDR_W).
  - Simultaneous write completion and new accept gives back-to-back writes at full throughput.
- Encoding (bit fields op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0]):
  - R: op=0x00, shamt=0, funct from alu_op: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - LW: 0x23 | rs | rt | imm.
  - SW: 0x2B | rs | rt | imm.
  - BEQ: 0x04 | rs | rt | imm.
  - J: 0x02 | target.
- Illegal input:
  - An illegal class, or an R-type with an unlisted alu_op, is consumed (handshake completes), not written, and sets err.
- Overflow:
  - in_valid while count==DEPTH in RUN sets err. in_ready is already 0.
- finish:
  - Latched in RUN. No further accepts after it.
  - finish coincident with an accept: the bundle is accepted and written, then the block goes to DONE.
- Reset mid-session: aborts immediately; a pending write is dropped (imem_we=0 next cycle). Memory contents are untouched.

Optional Feature:
- Macro: ENC_DELAY_SLOT_NOP_EN.
- Defined: after every BEQ or J word is written, the encoder inserts a NOP (0x00000000) at the next address.
  - in_ready is held low for that insertion cycle.
  - The NOP counts toward count/DEPTH.
  - If no room remains for the NOP, the branch itself is still written, the NOP is skipped, and err is set.
- Undefined: no insertion; words are written exactly as supplied.

Decomposition:
- Shared package instr_enc_pkg:
  - Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J).
  - Funct constants.
  - ALU operation codes matching the ALU controller encoding.
  - Instruction-class enum.
  - FSM state typedef.
- One sub-module, instr_word_pack: purely combinational field-to-word packer with a legal flag. It is reusable by the bench as its reference model.

Test Plan:
- start_addr=0x10; R add rs=1 rt=2 rd=3 -> imem_we 1 cycle after accept, addr 0x10, wdata 0x00221820, count=1.
- LW rs=4 rt=5 imm=0x0010, then SW rs=4 rt=5 imm=0xFFFC back-to-back -> 0x8C850010 @0x10, 0xAC85FFFC @0x11, no bubble.
- BEQ rs=1 rt=2 imm=3; J target=0x40 -> 0x10220003, 0x08000040. With ENC_DELAY_SLOT_NOP_EN each is followed by 0x00000000 and count=4.
- imem_ready low 3 cycles mid-stream -> imem_we/addr/wdata stable, in_ready=0, count unchanged until the write completes.
- DEPTH=4: 5 valid bundles -> 4 writes, in_ready=0 after the 4th, err=1, done=1; start_addr=0xFF wraps to addr 0x00 on the 2nd word.
- in_class=5 -> consumed, no imem_we, err=1. Reset asserted with a pending write -> imem_we=0 next cycle, state IDLE, count=0.
